// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, types and decode helpers for the memory stage
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {IDLE, BUSY} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    // Undefined funct3 values fall through to word size
    function automatic lsu_size_t accessSize(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] off);
        case (accessSize(f3))
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - EX/MEM inputs and MEM/WB outputs of the memory stage
interface mem_stage_lsu_if;
    logic        EnM;
    logic        FlushM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RdM;

    logic        StallM;
    logic        MisalignM;
    logic        ValidW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;

    modport master (
        output EnM, FlushM, RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M,
               ALUResultM, WriteDataM, PCPlus4M, RdM,
        input  StallM, MisalignM, ValidW, RegWriteW, ResultSrcW, RdW,
               ALUResultW, ReadDataW, PCPlus4W
    );

    modport slave (
        input  EnM, FlushM, RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M,
               ALUResultM, WriteDataM, PCPlus4M, RdM,
        output StallM, MisalignM, ValidW, RegWriteW, ResultSrcW, RdW,
               ALUResultW, ReadDataW, PCPlus4W
    );
endinterface

// File: rtl/lsu_data_ram.sv
// rtl/lsu_data_ram.sv - DEPTH x 32 data memory with byte write enables and async read
module lsu_data_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    // Byte-lane writes; contents are deliberately never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32 memory stage: load/store lanes, latency FSM, MEM/WB register
module mem_stage_lsu #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 0
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_lsu_if.slave bus
);
    import lsu_pkg::*;

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [2:0] LAT_CNT = 3'(LAT);

    lsu_state_t    state, stateNext;
    logic [2:0]    cnt, cntNext;
    logic          access, misalign, alignedAccess, valid;
    logic          stall, complete;
    logic [1:0]    offset;
    logic [AW-1:0] wordIdx;
    logic [3:0]    byteEn, ramWe;
    logic [31:0]   storeData, ramRdata, loadData;
    logic [15:0]   laneData;

    assign offset        = bus.ALUResultM[1:0];
    assign wordIdx       = bus.ALUResultM[AW+1:2];
    assign access        = bus.EnM & (bus.MemReadM | bus.MemWriteM) & ~bus.FlushM;
    assign misalign      = access & isMisaligned(bus.Funct3M, offset);
    assign alignedAccess = access & ~misalign;
    assign valid         = bus.EnM & ~bus.FlushM & ~misalign;

    assign bus.StallM    = stall;
    assign bus.MisalignM = misalign;

    // State and countdown register for multi-cycle accesses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next state, stall and completion; losing the access in BUSY aborts it
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stall     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (alignedAccess) begin
                    if (LAT_CNT == 3'd0) begin
                        complete = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        stateNext = BUSY;
                        cntNext   = LAT_CNT - 3'd1;
                    end
                end
            end
            BUSY: begin
                if (!alignedAccess) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt != 3'd0) begin
                    stall   = 1'b1;
                    cntNext = cnt - 3'd1;
                end else begin
                    complete  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Byte enables and lane-replicated store data from size and offset
    always_comb begin
        byteEn    = 4'b1111;
        storeData = bus.WriteDataM;
        case (accessSize(bus.Funct3M))
            SZ_B: begin
                byteEn    = 4'b0001 << offset;
                storeData = {4{bus.WriteDataM[7:0]}};
            end
            SZ_H: begin
                byteEn    = offset[1] ? 4'b1100 : 4'b0011;
                storeData = {2{bus.WriteDataM[15:0]}};
            end
            default: begin
            end
        endcase
    end

    // Reset gates the write so an access caught by reset never lands
    assign ramWe = (complete & bus.MemWriteM & rst) ? byteEn : 4'b0000;

    lsu_data_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .addr  (wordIdx),
        .we    (ramWe),
        .wdata (storeData),
        .rdata (ramRdata)
    );

    assign laneData = 16'(ramRdata >> {offset, 3'b000});

    // Lane select with sign or zero extension
    always_comb begin
        loadData = ramRdata;
        case (bus.Funct3M)
            F3_B:    loadData = {{24{laneData[7]}}, laneData[7:0]};
            F3_BU:   loadData = {24'b0, laneData[7:0]};
            F3_H:    loadData = {{16{laneData[15]}}, laneData[15:0]};
            F3_HU:   loadData = {16'b0, laneData[15:0]};
            default: loadData = ramRdata;
        endcase
    end

    // MEM/WB register: holds during a stall, otherwise loads fields or a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ValidW     <= 1'b0;
            bus.RegWriteW  <= 1'b0;
            bus.ResultSrcW <= '0;
            bus.RdW        <= '0;
            bus.ALUResultW <= '0;
            bus.ReadDataW  <= '0;
            bus.PCPlus4W   <= '0;
        end else if (!stall) begin
            bus.ValidW     <= valid;
            bus.RegWriteW  <= bus.RegWriteM & valid;
            bus.ResultSrcW <= valid ? bus.ResultSrcM : '0;
            bus.RdW        <= valid ? bus.RdM : '0;
            bus.ALUResultW <= valid ? bus.ALUResultM : '0;
            bus.ReadDataW  <= (valid & bus.MemReadM) ? loadData : '0;
            bus.PCPlus4W   <= valid ? bus.PCPlus4M : '0;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_lsu_if bus0();
    mem_stage_lsu_if bus3();

    mem_stage_lsu #(.DEPTH(1024), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_stage_lsu #(.DEPTH(16),   .LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    logic        sel = 1'b0;
    logic        en = 1'b0, flush = 1'b0, rw = 1'b0, mw = 1'b0, mr = 1'b0;
    logic [1:0]  rs = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] alu = '0, wd = '0, pc4 = '0;
    logic [4:0]  rd = '0;

    assign bus0.EnM = en & ~sel;
    assign bus3.EnM = en & sel;
    assign bus0.FlushM = flush;     assign bus3.FlushM = flush;
    assign bus0.RegWriteM = rw;     assign bus3.RegWriteM = rw;
    assign bus0.MemWriteM = mw;     assign bus3.MemWriteM = mw;
    assign bus0.MemReadM = mr;      assign bus3.MemReadM = mr;
    assign bus0.ResultSrcM = rs;    assign bus3.ResultSrcM = rs;
    assign bus0.Funct3M = f3;       assign bus3.Funct3M = f3;
    assign bus0.ALUResultM = alu;   assign bus3.ALUResultM = alu;
    assign bus0.WriteDataM = wd;    assign bus3.WriteDataM = wd;
    assign bus0.PCPlus4M = pc4;     assign bus3.PCPlus4M = pc4;
    assign bus0.RdM = rd;           assign bus3.RdM = rd;

    wire [31:0] obsStall = 32'(sel ? bus3.StallM : bus0.StallM);
    wire [31:0] obsMis   = 32'(sel ? bus3.MisalignM : bus0.MisalignM);
    wire [31:0] obsValid = 32'(sel ? bus3.ValidW : bus0.ValidW);
    wire [31:0] obsRegW  = 32'(sel ? bus3.RegWriteW : bus0.RegWriteW);
    wire [31:0] obsRsrc  = 32'(sel ? bus3.ResultSrcW : bus0.ResultSrcW);
    wire [31:0] obsRd    = 32'(sel ? bus3.RdW : bus0.RdW);
    wire [31:0] obsAlu   = sel ? bus3.ALUResultW : bus0.ALUResultW;
    wire [31:0] obsRdata = sel ? bus3.ReadDataW : bus0.ReadDataW;
    wire [31:0] obsPc4   = sel ? bus3.PCPlus4W : bus0.PCPlus4W;

    logic [31:0] mem0 [1024];
    logic [31:0] mem3 [16];
    logic [31:0] lastRead;
    int passCount = 0;
    int checkCount = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int modelSize(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [2:0] f, input logic [1:0] off);
        logic [31:0] lane;
        lane = w >> (8 * off);
        case (f)
            3'b000:  return ((lane & 32'hFF) >= 32'd128) ? (lane & 32'hFF) - 32'd256 : (lane & 32'hFF);
            3'b001:  return ((lane & 32'hFFFF) >= 32'd32768) ? (lane & 32'hFFFF) - 32'd65536 : (lane & 32'hFFFF);
            3'b100:  return lane & 32'hFF;
            3'b101:  return lane & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] modelStore(input logic [31:0] old, input logic [31:0] wdv, input logic [2:0] f, input logic [1:0] off);
        logic [31:0] mask;
        case (modelSize(f))
            1:       mask = 32'hFF;
            2:       mask = 32'hFFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << (8 * off);
        return (old & ~mask) | ((wdv << (8 * off)) & mask);
    endfunction

    // One instruction through the selected stage; flushAt >= 0 raises FlushM after that many stall cycles
    task automatic runInstr(input logic s, input logic e, input logic rwv, input logic mwv, input logic mrv,
                            input logic [1:0] rsv, input logic [2:0] f3v, input logic [31:0] a,
                            input logic [31:0] wdv, input logic [31:0] pcv, input logic [4:0] rdv, input int flushAt);
        int lat, sz, n, idx, expStall;
        logic isMem, mis, expValid;
        logic [31:0] depth, word;
        lat = s ? 3 : 0;
        sz = modelSize(f3v);
        isMem = mrv | mwv;
        mis = e && isMem && ((int'(a[1:0]) % sz) != 0);
        expStall = (e && isMem && !mis) ? lat : 0;
        if (flushAt >= 0) expStall = flushAt;
        depth = s ? 32'd16 : 32'd1024;
        idx = int'((a >> 2) % depth);
        word = s ? mem3[idx] : mem0[idx];

        @(negedge clk);
        sel = s; en = e; flush = 1'b0; rw = rwv; mw = mwv; mr = mrv;
        rs = rsv; f3 = f3v; alu = a; wd = wdv; pc4 = pcv; rd = rdv;
        n = 0;
        forever begin
            if (flushAt >= 0 && n == flushAt) flush = 1'b1;
            #1;
            if (n == 0) checkEq("misalign", obsMis, 32'(mis));
            if (obsStall == 32'd0) break;
            n++;
            if (n > 16) break;
            @(negedge clk);
        end
        checkEq("stall_cycles", 32'(n), 32'(expStall));

        expValid = e && !flush && !mis;
        @(posedge clk);
        #1;
        checkEq("valid_w", obsValid, 32'(expValid));
        checkEq("regwrite_w", obsRegW, 32'(rwv & expValid));
        checkEq("rd_w", obsRd, expValid ? 32'(rdv) : 32'd0);
        checkEq("resultsrc_w", obsRsrc, expValid ? 32'(rsv) : 32'd0);
        checkEq("alu_w", obsAlu, expValid ? a : 32'd0);
        checkEq("pc4_w", obsPc4, expValid ? pcv : 32'd0);
        if (expValid && mrv) checkEq("rdata_w", obsRdata, modelLoad(word, f3v, a[1:0]));
        else if (!expValid) checkEq("rdata_bubble", obsRdata, 32'd0);
        lastRead = obsRdata;
        if (expValid && mwv) begin
            if (s) mem3[idx] = modelStore(word, wdv, f3v, a[1:0]);
            else   mem0[idx] = modelStore(word, wdv, f3v, a[1:0]);
        end
        flush = 1'b0;
    endtask

    task automatic doLoad(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [4:0] r);
        runInstr(s, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, f, a, $urandom, $urandom, r, -1);
    endtask

    task automatic doStore(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        runInstr(s, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, f, a, d, $urandom, 5'($urandom), -1);
    endtask

    task automatic doAlu(input logic s, input logic [31:0] a, input logic [4:0] r);
        runInstr(s, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'($urandom), a, $urandom, $urandom, r, -1);
    endtask

    initial begin
        logic s;
        logic [2:0] f;
        logic [31:0] a;
        int k, fa;

        repeat (2) @(negedge clk);
        #1;
        checkEq("rst_valid0", 32'(bus0.ValidW), 32'd0);
        checkEq("rst_valid3", 32'(bus3.ValidW), 32'd0);
        checkEq("rst_stall3", 32'(bus3.StallM), 32'd0);
        checkEq("rst_alu3", bus3.ALUResultW, 32'd0);
        checkEq("rst_pc4_0", bus0.PCPlus4W, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) doStore(1'b1, 3'b010, 32'(i * 4), $urandom);
        for (int i = 0; i < 64; i++) doStore(1'b0, 3'b010, 32'(i * 4), $urandom);

        doStore(1'b0, 3'b010, 32'h40, 32'h1122_3344);
        doStore(1'b0, 3'b000, 32'h41, 32'h55AA_00AB);
        doLoad(1'b0, 3'b010, 32'h40, 5'd3);
        checkEq("sb_merge", lastRead, 32'h1122_AB44);

        doStore(1'b0, 3'b010, 32'h40, 32'h80FF_7F01);
        doLoad(1'b0, 3'b000, 32'h42, 5'd4);
        checkEq("lb_sext", lastRead, 32'hFFFF_FFFF);
        doLoad(1'b0, 3'b100, 32'h43, 5'd5);
        checkEq("lbu_zext", lastRead, 32'h0000_0080);
        doLoad(1'b0, 3'b001, 32'h42, 5'd6);
        checkEq("lh_sext", lastRead, 32'hFFFF_80FF);
        doLoad(1'b0, 3'b101, 32'h40, 5'd7);
        checkEq("lhu_zext", lastRead, 32'h0000_7F01);

        doLoad(1'b0, 3'b010, 32'h42, 5'd8);
        doStore(1'b0, 3'b001, 32'h45, 32'h0000_CAFE);
        doLoad(1'b0, 3'b010, 32'h44, 5'd9);

        doLoad(1'b1, 3'b010, 32'h08, 5'd10);
        doAlu(1'b1, 32'h0000_0123, 5'd11);

        runInstr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 32'h80, 32'hDEAD_BEEF, 32'h44, 5'd0, 2);
        doLoad(1'b1, 3'b010, 32'h80, 5'd12);

        doAlu(1'b1, 32'h0000_1234, 5'd13);
        @(negedge clk);
        sel = 1'b1; en = 1'b1; rw = 1'b0; mw = 1'b1; mr = 1'b0;
        f3 = 3'b010; alu = 32'h84; wd = 32'h0BAD_F00D; rd = 5'd0;
        #1;
        checkEq("busy_stall", obsStall, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkEq("rst_mid_valid", obsValid, 32'd0);
        checkEq("rst_mid_rd", obsRd, 32'd0);
        checkEq("rst_mid_alu", obsAlu, 32'd0);
        checkEq("rst_mid_pc4", obsPc4, 32'd0);
        en = 1'b0; mw = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        doLoad(1'b1, 3'b010, 32'h84, 5'd14);

        doStore(1'b1, 3'b010, 32'h40, 32'h5A5A_1234);
        doLoad(1'b1, 3'b010, 32'h00, 5'd15);
        checkEq("wrap_alias", lastRead, 32'h5A5A_1234);

        for (int i = 0; i < 300; i++) begin
            s = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 3);
            f = 3'($urandom_range(0, 7));
            a = s ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 255));
            fa = -1;
            if (s && k != 0 && k != 3 && (int'(a[1:0]) % modelSize(f)) == 0 && $urandom_range(0, 3) == 0)
                fa = $urandom_range(1, 3);
            case (k)
                0: doAlu(s, $urandom, 5'($urandom));
                1: runInstr(s, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, f, a, $urandom, $urandom, 5'($urandom), fa);
                2: runInstr(s, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, f, a, $urandom, $urandom, 5'($urandom), fa);
                default: runInstr(s, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), f, a,
                                  $urandom, $urandom, 5'($urandom), -1);
            endcase
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory stage of the 5-stage RV32 pipeline: a load/store unit with byte/halfword/word access, load sign/zero extension, misalignment detection and a configurable memory latency, followed by the MEM/WB pipeline register. It sits between the execute-stage EX/MEM register and writeback. When the configured latency is non-zero it stalls upstream through `StallM`.

## Interface
- `DEPTH`, 1024: data memory size in 32-bit words; power of two, at least 4.
- `LAT`, 0: extra cycles per memory access, 0..7. 0 gives single-cycle, stall-free access.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset. Single clock domain.
- `EnM`  in  1  valid instruction in M.
- `FlushM`  in  1  kill the M instruction, including any pending access.
- `RegWriteM`, `MemWriteM`, `MemReadM`  in  1 each  control bits.
- `ResultSrcM`  in  2  writeback mux select, passed through.
- `Funct3M`  in  3  access size and sign (RV32 load/store encoding).
- `ALUResultM`, `WriteDataM`, `PCPlus4M`  in  32 each  address / store data / PC+4.
- `RdM`  in  5  destination register.
- `StallM`  out  1  hold EX/MEM and earlier stages; combinational.
- `MisalignM`  out  1  one-cycle misaligned-access flag; combinational.
- `ValidW`, `RegWriteW`  out  1 each.
- `ResultSrcW`  out  2.
- `RdW`  out  5.
- `ALUResultW`, `ReadDataW`, `PCPlus4W`  out  32 each.

## Operation
- **Access decode.** An access is `EnM & (MemReadM | MemWriteM) & !FlushM`.
- **Word index.** `ALUResultM[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- **Misalignment.**
  - Halfword access with `addr[0]` = 1, or word access with `addr[1:0]` ≠ 0.
  - Result: no memory read or write, no stall, `MisalignM` = 1 in that cycle, and a bubble into W.
- **Stores (funct3 000/001/010 = SB/SH/SW).**
  - Per-byte write enables come from size and `addr[1:0]`.
  - Store data is replicated into all lanes: byte ×4, halfword ×2.
  - The write happens exactly once, on the completing edge.
- **Loads.**
  - Select the lane from `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU (100/101) zero-extend; LW (010) is unmodified.
  - Undefined funct3 values behave as LW/SW.
- **FSM states: IDLE, BUSY; 3-bit down-counter `cnt`.**
  - IDLE with an aligned access and `LAT` > 0: `StallM` = 1, go to BUSY, `cnt` ← `LAT`−1.
  - BUSY with `cnt` ≠ 0: `StallM` = 1, `cnt` decrements.
  - BUSY with `cnt` = 0: `StallM` = 0, the access completes, go to IDLE.
  - `LAT` = 0, or any non-memory instruction: completes in IDLE with no stall.
- **Upstream contract.** Upstream holds all M inputs stable while `StallM` = 1.
- **MEM/WB register.**
  - Loads the M fields when `StallM` = 0.
  - Holds its contents while `StallM` = 1.
  - `ValidW` = `EnM & !FlushM & !MisalignM`.
  - `RegWriteW` = `RegWriteM & ValidW`.
  - On a bubble, every W output loads 0.
- **FlushM while BUSY.** Abort the access: no write, go to IDLE, `cnt` = 0, `StallM` drops the same cycle, W loads a bubble.

## Timing
- **Reset** (`rst` low, asynchronous): state IDLE, `cnt` = 0, all W outputs 0. `StallM` and `MisalignM` read 0 unless M inputs drive them. Memory contents are not cleared.
- **Reset mid-BUSY:** the access is abandoned and no write occurs.
- **Latency:** a memory instruction's result appears at the W outputs `LAT`+1 edges after it is first presented in M. Non-memory instructions take 1 edge.
- **Throughput:** back-to-back accesses each cost `LAT`+1 cycles. There is no overlap.
- **Read-after-write** to the same word in consecutive instructions returns the new data, because the write commits before the next read samples.

## Structure
- Package `lsu_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - `ResultSrc` encodings.
  - FSM state enum `lsu_state_t` (IDLE, BUSY).
- Sub-module `lsu_data_ram`:
  - DEPTH×32 array, 4 byte write enables, combinational read port.
  - Writes on the clock edge; no reset of contents.
- The top level holds the FSM, lane logic and MEM/WB register. It should be roughly 200 lines.

## Test plan
- **Sub-word store, LAT=0:** SW 0x11223344 @0x40; SB 0xAB @0x41 → LW @0x40 gives `ReadDataW` = 0x1122AB44, no `StallM` ever.
- **Load extension:** word @0x40 = 0x80FF7F01 → LB @0x42 = 0xFFFFFFFF; LBU @0x43 = 0x00000080; LH @0x42 = 0xFFFF80FF; LHU @0x40 = 0x00007F01.
- **Misalignment:** LW @0x42 and SH @0x45 → `MisalignM` = 1 for one cycle, `ValidW` = 0, `RegWriteW` = 0, memory unchanged.
- **Latency, LAT=3:** LW → `StallM` high exactly 3 cycles, W updated on the 4th edge; the following ADD reaches W one edge later.
- **Flush, LAT=3:** SW 0xDEADBEEF @0x80 with `FlushM` in the 2nd BUSY cycle → `StallM` drops that cycle; a later LW @0x80 returns the old value.
- **Reset and wrap:** async `rst` low mid-BUSY → all W outputs 0 immediately, no write. Wrap: with DEPTH=16, SW @0x40 aliases @0x00.
